// File: rtl/data_memory.sv
// RV32I load/store data memory with valid/ready request handshake,
// configurable response latency and fault reporting.
module data_memory #(
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_pend_rdata;
  logic        r_pend_fault;

  logic          w_accept;
  logic          w_legal;
  logic          w_misalign;
  logic          w_oor;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_sext;
  logic [31:0]   w_ld;
  logic [31:0]   w_rdata;
  logic [3:0]    w_be;
  logic [31:0]   w_lane;
  logic          w_we;

  assign req_ready = (r_state != S_WAIT);
  assign w_accept  = req_valid && req_ready && !rst;

  // Stores only exist for the three unsigned-free widths.
  assign w_legal = req_write
                 ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                 : (req_funct3[1:0] != 2'b11 &&
                    !(req_funct3[2] && req_funct3[1]));

  assign w_misalign =
      (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

  assign w_oor   = |req_addr[31:AW+2];
  assign w_fault = !w_legal || w_misalign || w_oor;
  assign w_idx   = req_addr[AW+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {req_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = req_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_sext  = !req_funct3[2];

  always_comb begin
    w_ld   = w_word;
    w_be   = 4'b0000;
    w_lane = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        w_ld   = {{24{w_sext & w_byte[7]}}, w_byte};
        w_be   = 4'b0001 << req_addr[1:0];
        w_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_ld   = {{16{w_sext & w_half[15]}}, w_half};
        w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_be = 4'b1111;
      end
      default: begin
        w_be = 4'b0000;
      end
    endcase
  end

  assign w_rdata = (w_fault || req_write) ? 32'h0 : w_ld;
  assign w_we    = w_accept && req_write && !w_fault;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_lane[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    resp_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next     = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
          w_cnt_next = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_next     = S_RESP;
          w_cnt_next = 3'd0;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (w_accept) begin
          w_next     = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
          w_cnt_next = CNT_INIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Response fields move only on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_rdata <= 32'h0;
      r_pend_fault <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_fault   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_rdata <= w_rdata;
        r_pend_fault <= w_fault;
      end
      if (w_accept && READ_LATENCY == 1) begin
        resp_rdata <= w_rdata;
        resp_fault <= w_fault;
      end else if (r_state == S_WAIT && w_next == S_RESP) begin
        resp_rdata <= r_pend_rdata;
        resp_fault <= r_pend_fault;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance with latency 1,
// one with latency 3, both checked against a byte-level memory model.
module tb_data_memory;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rd;
    logic        ft;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld  [2];
  logic        wr   [2];
  logic [2:0]  f3   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic [31:0] rd   [2];
  logic        ft   [2];

  logic [31:0] m [2][DEPTH];
  exp_t q0[$];
  exp_t q1[$];
  int   cyc   = 0;
  int   nvec  = 0;
  int   nfail = 0;

  localparam logic [32:0] FLT = {1'b1, 32'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_write(wr[0]), .req_funct3(f3[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_fault(ft[0])
  );

  data_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst),
    .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_write(wr[1]), .req_funct3(f3[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_fault(ft[1])
  );

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Reference: access size in bytes, alignment as a modulus, lanes as
  // byte offsets into the word.
  function automatic logic [32:0] ref_acc(int k, logic w, logic [2:0] f,
                                          logic [31:0] a, logic [31:0] d);
    int          sz;
    int          idx;
    int          off;
    logic [31:0] v;
    logic [31:0] msk;
    case (f)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (sz == 0 || (w && f[2])) return FLT;
    if ((a % sz) != 0) return FLT;
    if ((a / 4) >= DEPTH) return FLT;
    idx = int'(a / 4);
    off = int'(a % 4);
    if (w) begin
      v = m[k][idx];
      for (int i = 0; i < sz; i++) v[8*(off+i) +: 8] = d[8*i +: 8];
      m[k][idx] = v;
      return 33'h0;
    end
    v   = m[k][idx] >> (8 * off);
    msk = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
    v   = v & msk;
    if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~msk;
    return {1'b0, v};
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] ex);
    nvec++;
    if (act !== ex) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, act, ex);
    end
  endfunction

  task automatic push(int k, logic [32:0] r, int due);
    exp_t e;
    e.rd  = r[31:0];
    e.ft  = r[32];
    e.due = due;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic issue(int k, logic w, logic [2:0] f, logic [31:0] a,
                       logic [31:0] d, bit use_ex, logic [32:0] ex);
    logic [32:0] r;
    int          n;
    n = 0;
    @(negedge clk);
    vld[k] = 1'b1; wr[k] = w; f3[k] = f; addr[k] = a; wd[k] = d;
    while (!rdy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[k]) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout inst%0d ready %b want 1", k, rdy[k]);
      vld[k] = 1'b0;
      return;
    end
    r = ref_acc(k, w, f, a, d);
    if (use_ex) r = ex;
    push(k, r, cyc + lat(k));
    @(posedge clk);
    #1 vld[k] = 1'b0;
  endtask

  task automatic go(int k, logic w, logic [2:0] f, logic [31:0] a,
                    logic [31:0] d);
    issue(k, w, f, a, d, 1'b0, 33'h0);
  endtask

  task automatic gox(int k, logic w, logic [2:0] f, logic [31:0] a,
                     logic [31:0] d, logic [32:0] ex);
    issue(k, w, f, a, d, 1'b1, ex);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic directed(int k);
    for (int i = 0; i < DEPTH; i++) go(k, 1'b1, 3'd2, 32'(i * 4), $urandom);
    gox(k, 1, 3'd2, 32'h10, 32'hDEADBEEF, 33'h0);
    gox(k, 0, 3'd2, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF});
    gox(k, 1, 3'd2, 32'h20, 32'h80F07F01, 33'h0);
    gox(k, 0, 3'd0, 32'h23, 32'h0, {1'b0, 32'hFFFFFF80});
    gox(k, 0, 3'd4, 32'h23, 32'h0, {1'b0, 32'h00000080});
    gox(k, 0, 3'd1, 32'h22, 32'h0, {1'b0, 32'hFFFF80F0});
    gox(k, 0, 3'd5, 32'h20, 32'h0, {1'b0, 32'h00007F01});
    gox(k, 1, 3'd2, 32'h78, 32'hFFFFFFFF, 33'h0);
    gox(k, 1, 3'd0, 32'h79, 32'h00000012, 33'h0);
    gox(k, 1, 3'd1, 32'h7A, 32'h0000ABCD, 33'h0);
    gox(k, 0, 3'd2, 32'h78, 32'h0, {1'b0, 32'hABCD12FF});
    gox(k, 0, 3'd2, 32'h22, 32'h0, FLT);
    gox(k, 1, 3'd1, 32'h21, 32'h00001234, FLT);
    gox(k, 0, 3'd3, 32'h20, 32'h0, FLT);
    gox(k, 1, 3'd4, 32'h20, 32'h0000FFFF, FLT);
    gox(k, 0, 3'd2, 32'h400, 32'h0, FLT);
    gox(k, 1, 3'd2, 32'h400, 32'h00000099, FLT);
    gox(k, 1, 3'd2, 32'h3FC, 32'h0BADF00D, 33'h0);
    gox(k, 0, 3'd2, 32'h20, 32'h0, {1'b0, 32'h80F07F01});
    gox(k, 0, 3'd2, 32'h3FC, 32'h0, {1'b0, 32'h0BADF00D});
    go(k, 0, 3'd2, 32'h0, 32'h0);
  endtask

  task automatic random_ops(int k, int n);
    logic [31:0] a;
    int          sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
      else               a = 32'($urandom_range(0, DEPTH * 4 - 1));
      go(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
  endtask

  task automatic handshake();
    bit          er [6];
    int          nacc;
    logic [31:0] a;
    er   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      vld[1] = 1'b1; wr[1] = 1'b0; f3[1] = 3'd2; addr[1] = a; wd[1] = 32'h0;
      chk($sformatf("hs_ready_c%0d", i), 32'(rdy[1]), 32'(er[i]));
      if (rdy[1]) begin
        nacc++;
        push(1, ref_acc(1, 1'b0, 3'd2, a, 32'h0), cyc + 3);
      end
    end
    @(posedge clk);
    #1 vld[1] = 1'b0;
    chk("hs_accepts", 32'(nacc), 32'd2);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    vld[1] = 1'b1; wr[1] = 1'b1; f3[1] = 3'd2; addr[1] = 32'h0;
    wd[1] = 32'h55;
    chk("rst_pre_ready", 32'(rdy[1]), 32'd1);
    void'(ref_acc(1, 1'b1, 3'd2, 32'h0, 32'h55));
    @(posedge clk);
    #1 vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_ready", 32'(rdy[1]), 32'd1);
    chk("rst_async_valid", 32'(rv[1]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(rv[1]), 32'd0);
      chk("rst_hold_ready", 32'(rdy[1]), 32'd1);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after_valid", 32'(rv[1]), 32'd0);
    end
    gox(1, 0, 3'd2, 32'h0, 32'h0, {1'b0, 32'h00000055});
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   empty;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          nvec++;
          empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            nfail++;
            $display("FAIL unexpected_resp inst%0d rdata %h fault %b",
                     k, rd[k], ft[k]);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (rd[k] !== e.rd || ft[k] !== e.ft || cyc != e.due) begin
              nfail++;
              $display("FAIL resp inst%0d got %h/%b @%0d want %h/%b @%0d",
                       k, rd[k], ft[k], cyc, e.rd, e.ft, e.due);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; wr[k] = 1'b0; f3[k] = 3'd0;
      addr[k] = 32'h0; wd[k] = 32'h0;
      for (int i = 0; i < DEPTH; i++) m[k][i] = 32'h0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ready%0d", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("reset_valid%0d", k), 32'(rv[k]), 32'd0);
      chk($sformatf("reset_rdata%0d", k), rd[k], 32'd0);
      chk($sformatf("reset_fault%0d", k), 32'(ft[k]), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      directed(k);
      random_ops(k, 300);
      settle();
    end
    handshake();
    settle();
    reset_mid();
    repeat (10) @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
